// File: rtl/sevseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package sevseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Index 15 is leftmost: F, E, d, C, b, A, 9 .. 0
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h38, 7'h30, 7'h42, 7'h31,
        7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C,
        7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic {
        BLANK,
        SCAN
    } sevseg_state_t;

endpackage

// File: rtl/sevseg_decode.sv
// Nibble to active-low seven-segment pattern.
// Purely combinational; shared with the debug display path.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/sevseg_scan_driver.sv
// Double-buffered 8-digit seven-segment scanner with dwell, blanking,
// blink and decimal points. Runs entirely in the clk_7seg domain.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DWELL        = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk_7seg,
    input  logic              Rst,
    input  logic [31:0]       value_in,
    input  logic              value_valid,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] blink_mask,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        sev_out,
    output logic              dp_n,
    output logic              frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    sevseg_state_t     state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     dwell_cnt_q, dwell_cnt_d;
    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [31:0]       pending_q, pending_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        sev_q, sev_d;
    logic              dp_n_q, dp_n_d;
    logic              frame_done_q, frame_done_d;

    logic              fb;
    logic [3:0]        nib;
    logic [6:0]        seg;
    logic              lz_blank;
    logic              blink_blank;
    logic              blanked;

    sevseg_decode u_decode (
        .nib (nib),
        .seg (seg)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dwell_cnt_d   = dwell_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        pending_d     = pending_q;
        shadow_d      = shadow_q;

        fb = (state_q == SCAN) && (idx_q == IDX_LAST)
             && (dwell_cnt_q == DWELL_LAST);

        if (value_valid) pending_d = value_in;

        unique case (state_q)
            BLANK: begin
                state_d     = SCAN;
                idx_d       = '0;
                dwell_cnt_d = '0;
            end
            SCAN: begin
                if (dwell_cnt_q == DWELL_LAST) begin
                    dwell_cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
                if (fb) begin
                    // A strobe on the boundary itself lands in this frame swap
                    shadow_d = value_valid ? value_in : pending_q;
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
        endcase

        // Outputs are built from next-state so they line up with idx_q
        nib         = shadow_d[{idx_d, 2'b00} +: 4];
        lz_blank    = blank_lz && (idx_d != '0)
                      && ((shadow_d >> {idx_d, 2'b00}) == 32'd0);
        blink_blank = blink_phase_d && blink_mask[idx_d];
        blanked     = (state_d != SCAN) || lz_blank || blink_blank;

        an_d         = blanked ? AN_OFF : ~(DIGITS'(1) << idx_d);
        sev_d        = blanked ? SEG_BLANK : seg;
        dp_n_d       = blanked || !dp_mask[idx_d];
        frame_done_d = (state_d == SCAN) && (idx_d == IDX_LAST)
                       && (dwell_cnt_d == DWELL_LAST);
    end

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            state_q       <= BLANK;
            idx_q         <= '0;
            dwell_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= '0;
            shadow_q      <= '0;
            an_q          <= AN_OFF;
            sev_q         <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dwell_cnt_q   <= dwell_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            sev_q         <= sev_d;
            dp_n_q        <= dp_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign sev_out    = sev_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Bench for sevseg_scan_driver: cycle-count based reference model,
// directed steps followed by a randomized stretch.
module tb_sevseg_scan_driver;

    localparam int D  = 2;
    localparam int BF = 2;
    localparam int FL = 8 * D;

    logic        clk_7seg = 1'b0;
    logic        Rst;
    logic [31:0] value_in;
    logic        value_valid;
    logic        blank_lz;
    logic [7:0]  blink_mask;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        dp_n;
    logic        frame_done;

    always #5 clk_7seg = ~clk_7seg;

    sevseg_scan_driver #(
        .DIGITS       (8),
        .DWELL        (D),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_7seg    (clk_7seg),
        .Rst         (Rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .blank_lz    (blank_lz),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .an          (an),
        .sev_out     (sev_out),
        .dp_n        (dp_n),
        .frame_done  (frame_done)
    );

    logic [6:0] lut [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // c = edges since the last reset edge; c==0 is the blank cycle
    int          c = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_shadow = '0;
    logic [7:0]  e_an;
    logic [6:0]  e_sev;
    logic        e_dp;
    logic        e_fd;
    int          checks = 0;
    int          errors = 0;

    function automatic logic cur_fb();
        return (c >= 1) && (((c - 1) % FL) == FL - 1);
    endfunction

    function automatic int cur_idx();
        return (c >= 1) ? ((c - 1) / D) % 8 : -1;
    endfunction

    task automatic model_edge();
        int k, idx, frame, ph;
        logic blk;
        if (Rst) begin
            c = 0;
            m_pend = '0;
            m_shadow = '0;
        end else begin
            if (cur_fb()) m_shadow = value_valid ? value_in : m_pend;
            if (value_valid) m_pend = value_in;
            c++;
        end
        if (c == 0) begin
            e_an = 8'hFF; e_sev = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            k     = c - 1;
            idx   = (k / D) % 8;
            frame = k / FL;
            ph    = (frame / BF) % 2;
            e_fd  = (k % FL) == FL - 1;
            blk   = (idx > 0 && blank_lz && (m_shadow >> (4 * idx)) == 0)
                    || (ph == 1 && blink_mask[idx]);
            e_an  = blk ? 8'hFF : ~(8'd1 << idx);
            e_sev = blk ? 7'h7F : lut[(m_shadow >> (4 * idx)) & 32'hF];
            e_dp  = blk ? 1'b1 : ~dp_mask[idx];
        end
    endtask

    task automatic compare();
        checks++;
        assert (an === e_an) else begin
            errors++;
            $error("FAIL an c=%0d got %h exp %h", c, an, e_an);
        end
        checks++;
        assert (sev_out === e_sev) else begin
            errors++;
            $error("FAIL sev c=%0d got %b exp %b", c, sev_out, e_sev);
        end
        checks++;
        assert (dp_n === e_dp) else begin
            errors++;
            $error("FAIL dp_n c=%0d got %b exp %b", c, dp_n, e_dp);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL frame_done c=%0d got %b exp %b", c, frame_done, e_fd);
        end
    endtask

    task automatic step(input logic r, input logic vv, input logic [31:0] v);
        Rst = r;
        value_valid = vv;
        value_in = v;
        @(posedge clk_7seg);
        model_edge();
        @(negedge clk_7seg);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
    endtask

    initial begin
        Rst = 1'b1; value_valid = 1'b0; value_in = '0;
        blank_lz = 1'b0; blink_mask = '0; dp_mask = '0;
        @(negedge clk_7seg);

        // Reset, then scan zeros: blank cycle, FE..7F, frame_done every FL
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        idle(2 * FL);

        // Mid-frame load shows up only at the next frame start
        for (int i = 0; i < FL + 2 && cur_idx() != 3; i++) idle(1);
        step(1'b0, 1'b1, 32'h12345678);
        idle(2 * FL);

        // Strobe on the boundary cycle bypasses straight into the shadow
        for (int i = 0; i < FL + 2 && !cur_fb(); i++) idle(1);
        step(1'b0, 1'b1, 32'hABCD0000);
        idle(FL);

        // Leading-zero blanking
        blank_lz = 1'b1;
        step(1'b0, 1'b1, 32'h00000105);
        idle(3 * FL);

        // Blink on digit 0, decimal point on digit 1
        blank_lz = 1'b0;
        blink_mask = 8'h01;
        dp_mask = 8'h02;
        idle(8 * FL);

        // Randomized stretch
        for (int i = 0; i < 400; i++) begin
            if (i % 23 == 0) begin
                blank_lz   = 1'($urandom);
                blink_mask = 8'($urandom);
                dp_mask    = 8'($urandom);
            end
            step(1'b0, ($urandom % 8) == 0,
                 ($urandom % 2 == 0) ? ($urandom >> ($urandom % 32)) : $urandom);
        end

        // Reset in the middle of a scan aborts the frame and clears shadow
        blank_lz = 1'b0;
        blink_mask = '0;
        dp_mask = 8'h10;
        step(1'b0, 1'b1, 32'h87654321);
        for (int i = 0; i < 3 * FL && cur_idx() != 4; i++) idle(1);
        step(1'b1, 1'b0, '0);
        idle(2 * FL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
